rename_regfile_ckpt: RTL

- Parametrised architectural register file with rename (ROB-tag) tracking. Has NRD read ports, two in-order commit ports and a circular bank of dependency-table checkpoints.
- Sits between the decoder/issue stage and the ROB.
- On a branch mispredict it restores the rename table from a checkpoint instead of flushing every dependency.

---
 rtl/rename_regfile_ckpt_if.sv | 54 +++++
 rtl/rename_regfile_ckpt.sv | 110 +++++++++++
 2 files changed

// File: rtl/rename_regfile_ckpt_if.sv
// Bundles the decode/issue, commit, operand-read and checkpoint signals of the
// rename register file; master is the pipeline side, slave is the register file.
interface rename_regfile_ckpt_if #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int ROB_WIDTH = 4,
  parameter int NRD       = 2,
  parameter int NCKPT     = 4
);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);

  logic                     rdy_in;
  logic                     clear;
  logic                     c0_valid;
  logic [RW-1:0]            c0_reg;
  logic [XLEN-1:0]          c0_val;
  logic [ROB_WIDTH-1:0]     c0_rob;
  logic                     c1_valid;
  logic [RW-1:0]            c1_reg;
  logic [XLEN-1:0]          c1_val;
  logic [ROB_WIDTH-1:0]     c1_rob;
  logic                     iss_valid;
  logic [RW-1:0]            iss_rd;
  logic [ROB_WIDTH-1:0]     iss_rob;
  logic [NRD*RW-1:0]        rd_reg;
  logic [NRD-1:0]           rd_has_dep;
  logic [NRD*ROB_WIDTH-1:0] rd_rob;
  logic [NRD*XLEN-1:0]      rd_val;
  logic                     ck_take;
  logic [CW-1:0]            ck_id;
  logic                     ck_full;
  logic                     ck_release;
  logic                     ck_restore;
  logic [CW-1:0]            ck_restore_id;

  modport master (
    output rdy_in, clear,
    output c0_valid, c0_reg, c0_val, c0_rob,
    output c1_valid, c1_reg, c1_val, c1_rob,
    output iss_valid, iss_rd, iss_rob, rd_reg,
    output ck_take, ck_release, ck_restore, ck_restore_id,
    input  rd_has_dep, rd_rob, rd_val, ck_id, ck_full
  );

  modport slave (
    input  rdy_in, clear,
    input  c0_valid, c0_reg, c0_val, c0_rob,
    input  c1_valid, c1_reg, c1_val, c1_rob,
    input  iss_valid, iss_rd, iss_rob, rd_reg,
    input  ck_take, ck_release, ck_restore, ck_restore_id,
    output rd_has_dep, rd_rob, rd_val, ck_id, ck_full
  );
endinterface

// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with ROB-tag rename tracking and a circular bank
// of dependency-table checkpoints used for fast mispredict recovery.
module rename_regfile_ckpt #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int ROB_WIDTH = 4,
  parameter int NRD       = 2,
  parameter int NCKPT     = 4
) (
  input logic clk_in,
  input logic rst_in,
  rename_regfile_ckpt_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);

  logic [XLEN-1:0]      val_q  [NREG];
  logic [ROB_WIDTH-1:0] dep_q  [NREG];
  logic [NREG-1:0]      has_q;
  logic [ROB_WIDTH-1:0] cdep_q [NCKPT][NREG];
  logic [NREG-1:0]      chas_q [NCKPT];
  logic [CW-1:0]        head_q;
  logic [CW-1:0]        tail_q;
  logic [CW:0]          count_q;

  logic [ROB_WIDTH-1:0] nxt_dep [NREG];
  logic [NREG-1:0]      nxt_has;
  logic [NREG-1:0]      chas_nx [NCKPT];

  assign bus.ck_id   = tail_q;
  assign bus.ck_full = (count_q == (CW+1)'(NCKPT));

  // Operand reads forward a same-cycle commit whose tag matches the pending producer.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [RW-1:0] r;
    logic          hit0;
    logic          hit1;
    assign r    = bus.rd_reg[k*RW +: RW];
    assign hit0 = bus.c0_valid && (bus.c0_rob == dep_q[r]);
    assign hit1 = bus.c1_valid && (bus.c1_rob == dep_q[r]);
    assign bus.rd_rob[k*ROB_WIDTH +: ROB_WIDTH] = dep_q[r];
    assign bus.rd_has_dep[k] = has_q[r] && !hit0 && !hit1;
    assign bus.rd_val[k*XLEN +: XLEN] = !has_q[r] ? val_q[r] :
                                        hit0      ? bus.c0_val :
                                        hit1      ? bus.c1_val : '0;
  end

  always_comb begin
    nxt_has = has_q;
    for (int i = 0; i < NREG; i++) nxt_dep[i] = dep_q[i];
    if (bus.c0_valid && dep_q[bus.c0_reg] == bus.c0_rob) nxt_has[bus.c0_reg] = 1'b0;
    if (bus.c1_valid && dep_q[bus.c1_reg] == bus.c1_rob) nxt_has[bus.c1_reg] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0) begin
      nxt_dep[bus.iss_rd] = bus.iss_rob;
      nxt_has[bus.iss_rd] = 1'b1;
    end
  end

  // Dead slots are cleaned too; they are always overwritten before reuse.
  always_comb begin
    for (int s = 0; s < NCKPT; s++) begin
      chas_nx[s] = chas_q[s];
      if (bus.c0_valid && cdep_q[s][bus.c0_reg] == bus.c0_rob) chas_nx[s][bus.c0_reg] = 1'b0;
      if (bus.c1_valid && cdep_q[s][bus.c1_reg] == bus.c1_rob) chas_nx[s][bus.c1_reg] = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      has_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        dep_q[i] <= '0;
      end
      for (int s = 0; s < NCKPT; s++) begin
        chas_q[s] <= '0;
        for (int i = 0; i < NREG; i++) cdep_q[s][i] <= '0;
      end
    end else if (bus.rdy_in) begin
      if (bus.c0_valid && bus.c0_reg != '0) val_q[bus.c0_reg] <= bus.c0_val;
      if (bus.c1_valid && bus.c1_reg != '0) val_q[bus.c1_reg] <= bus.c1_val;
      for (int s = 0; s < NCKPT; s++) chas_q[s] <= chas_nx[s];
      if (bus.clear) begin
        has_q   <= '0;
        head_q  <= tail_q;
        count_q <= '0;
        for (int i = 0; i < NREG; i++) dep_q[i] <= '0;
      end else if (bus.ck_restore) begin
        has_q   <= chas_nx[bus.ck_restore_id];
        for (int i = 0; i < NREG; i++) dep_q[i] <= cdep_q[bus.ck_restore_id][i];
        tail_q  <= bus.ck_restore_id;
        head_q  <= head_q + CW'(bus.ck_release);
        count_q <= {1'b0, bus.ck_restore_id - head_q} - (CW+1)'(bus.ck_release);
      end else begin
        has_q <= nxt_has;
        for (int i = 0; i < NREG; i++) dep_q[i] <= nxt_dep[i];
        if (bus.ck_take) begin
          chas_q[tail_q] <= nxt_has;
          for (int i = 0; i < NREG; i++) cdep_q[tail_q][i] <= nxt_dep[i];
          tail_q <= tail_q + 1'b1;
        end
        head_q  <= head_q + CW'(bus.ck_release);
        count_q <= count_q + (CW+1)'(bus.ck_take) - (CW+1)'(bus.ck_release);
      end
    end
  end
endmodule
